simon_input_checker: RTL and testbench

//  Player-side half of the Simon game. Stores the colour sequence that the display FSM

---
 rtl/simon_input_checker.sv | 196 +++++++++++++++++++
 tb/tb_simon_input_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_input_checker.sv
// simon_input_checker
//   Player-side half of the Simon game. Holds the colour sequence written by the
//   game FSM, then debounces the four player buttons and checks each accepted
//   press against the stored sequence in order, reporting a per-round verdict
//   and keeping the score of the last passed round.
//
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   tick       : clock-enable strobe; all debounce/timeout timing counts ticks
//   seq_clear  : empty the sequence store (IDLE only, wins over seq_wr)
//   seq_wr     : append seq_colour to the store (IDLE only, ignored when full)
//   seq_colour : one-hot expected colour (not validated on write)
//   arm        : start checking the stored sequence (IDLE only, needs len != 0)
//   button     : raw asynchronous player buttons, active-high
//   busy       : high from accepted arm until the verdict cycle
//   round_ok   : 1-cycle pulse, whole sequence entered correctly
//   round_fail : 1-cycle pulse, wrong, multiple or late press
//   led        : echo of the currently accepted button, 0 otherwise
//   score      : length of the last passed round, saturating at 15
//
// Optional feature
//   SIMON_CHECK_TIMEOUT_EN : per-press timeout of TIMEOUT_TICKS ticks
//   (undefined: no timer, the checker waits indefinitely for a press).

module simon_input_checker #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned DEBOUNCE_TICKS = 20000,
  parameter int unsigned TIMEOUT_TICKS  = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       seq_clear,
  input  logic       seq_wr,
  input  logic [3:0] seq_colour,
  input  logic       arm,
  input  logic [3:0] button,
  output logic       busy,
  output logic       round_ok,
  output logic       round_fail,
  output logic [3:0] led,
  output logic [3:0] score
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned LW = IW + 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DEB_LIM = CW'(DEBOUNCE_TICKS);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PRESS, S_DEB_PRESS, S_WAIT_REL, S_PASS, S_FAIL
  } state_t;

  state_t        state, state_next;
  logic [3:0]    sync1, btn;
  logic [3:0]    mem [MAX_LEN];
  logic [LW-1:0] len;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;
  logic          cnt_hit, last, cand_bad, timeout_hit;
  logic          busy_d, ok_d, fail_d;

  assign cnt_hit  = (cnt + 1'b1) == DEB_LIM;
  assign last     = ({1'b0, idx} + 1'b1) == len;
  assign cand_bad = !$onehot(cand) || (cand != mem[idx]);

`ifdef SIMON_CHECK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_TICKS);
  logic [TW-1:0] timer;
  logic          in_press;

  assign in_press    = (state == S_WAIT_PRESS) || (state == S_DEB_PRESS);
  assign timeout_hit = tick && in_press && ((timer + 1'b1) == TO_LIM);

  // Restarts on every entry to WAIT_PRESS, including a bounce back from DEB_PRESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state_next == S_WAIT_PRESS && state != S_WAIT_PRESS) begin
      timer <= '0;
    end else if (tick && in_press) begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; outputs are registered from the next-state decode so the
  // verdict pulse and the fall of busy land in the same cycle as PASS/FAIL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      round_ok   <= 1'b0;
      round_fail <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= busy_d;
      round_ok   <= ok_d;
      round_fail <= fail_d;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (arm && len != '0) state_next = S_WAIT_PRESS;
      S_WAIT_PRESS: begin
        if (timeout_hit)      state_next = S_FAIL;
        else if (btn != '0)   state_next = S_DEB_PRESS;
      end
      S_DEB_PRESS: begin
        if (timeout_hit)      state_next = S_FAIL;
        else if (tick) begin
          if (btn != cand)    state_next = S_WAIT_PRESS;
          else if (cnt_hit)   state_next = cand_bad ? S_FAIL : S_WAIT_REL;
        end
      end
      S_WAIT_REL:   if (tick && btn == '0 && cnt_hit) state_next = last ? S_PASS : S_WAIT_PRESS;
      S_PASS:       state_next = S_IDLE;
      S_FAIL:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_next == S_WAIT_PRESS) || (state_next == S_DEB_PRESS) ||
             (state_next == S_WAIT_REL);
    ok_d   = (state_next == S_PASS);
    fail_d = (state_next == S_FAIL);
  end

  // Synchroniser, sequence store and per-press datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      btn   <= '0;
      len   <= '0;
      idx   <= '0;
      cnt   <= '0;
      cand  <= '0;
      led   <= '0;
      score <= '0;
    end else begin
      sync1 <= button;
      btn   <= sync1;
      unique case (state)
        S_IDLE: begin
          if (seq_clear) begin
            len <= '0;
          end else if (seq_wr && len < LEN_MAX) begin
            mem[len[IW-1:0]] <= seq_colour;
            len <= len + 1'b1;
          end
          if (state_next == S_WAIT_PRESS) idx <= '0;
        end
        S_WAIT_PRESS: begin
          cnt <= '0;
          if (btn != '0) cand <= btn;
        end
        S_DEB_PRESS: begin
          if (tick && btn == cand) begin
            if (cnt_hit) begin
              cnt <= '0;
              if (state_next == S_WAIT_REL) led <= cand;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WAIT_REL: begin
          if (tick) begin
            if (btn != '0) begin
              cnt <= '0;
            end else if (cnt_hit) begin
              cnt <= '0;
              led <= '0;
              if (!last) idx <= idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (state_next == S_PASS) score <= (32'(len) > 32'd15) ? 4'd15 : 4'(len);
      if (state_next == S_FAIL) led <= '0;
    end
  end

endmodule

// File: tb/tb_simon_input_checker.sv
module tb_simon_input_checker;

  logic       clk = 1'b0;
  logic       reset, tick, seq_clear, seq_wr, arm;
  logic [3:0] seq_colour, button;
  logic       busy, round_ok, round_fail;
  logic [3:0] led, score;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       ok;
    logic [3:0] score;
  } verdict_t;

  typedef struct {
    logic [3:0] stored;
    logic [3:0] pressed;
    logic       exp_ok;
    logic [3:0] exp_led;
  } vec_t;

  verdict_t   exp_q[$];
  vec_t       vecs[7];
  logic [3:0] exp_score = 4'd0;

  simon_input_checker #(
    .MAX_LEN(16),
    .DEBOUNCE_TICKS(2),
    .TIMEOUT_TICKS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .seq_clear(seq_clear),
    .seq_wr(seq_wr),
    .seq_colour(seq_colour),
    .arm(arm),
    .button(button),
    .busy(busy),
    .round_ok(round_ok),
    .round_fail(round_fail),
    .led(led),
    .score(score)
  );

  always #5 clk = ~clk;

  // Scoreboard: every verdict pulse must match the oldest expected verdict.
  always @(negedge clk) begin
    verdict_t v;
    if (!reset && (round_ok || round_fail)) begin
      checks++;
      if (round_ok && round_fail) begin
        failures++;
        $display("FAIL verdict_both: ok=%0b fail=%0b, required exactly one", round_ok, round_fail);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_verdict: ok=%0b fail=%0b score=%0d, required no pulse",
                 round_ok, round_fail, score);
      end else begin
        v = exp_q.pop_front();
        if (round_ok !== v.ok || score !== v.score || busy !== 1'b0) begin
          failures++;
          $display("FAIL verdict: ok=%0b score=%0d busy=%0b, required ok=%0b score=%0d busy=0",
                   round_ok, score, busy, v.ok, v.score);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    seq_clear = 1'b1;
    step();
    seq_clear = 1'b0;
  endtask

  task automatic wr(input logic [3:0] c);
    seq_colour = c;
    seq_wr = 1'b1;
    step();
    seq_wr = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic expect_verdict(input logic ok, input logic [3:0] sc);
    verdict_t v;
    v.ok = ok;
    v.score = sc;
    exp_q.push_back(v);
  endtask

  // Hold long enough for sync + debounce, then release long enough for the
  // release debounce; stays well inside an 8-tick per-press timeout.
  task automatic press(input logic [3:0] b, input logic [3:0] exp_led, input string name);
    button = b;
    repeat (6) step();
    check(name, 32'(led), 32'(exp_led));
    button = 4'b0;
    repeat (5) step();
  endtask

  initial begin
    logic [3:0] c;

    vecs[0] = '{stored: 4'b0100, pressed: 4'b0100, exp_ok: 1'b1, exp_led: 4'b0100};
    vecs[1] = '{stored: 4'b0100, pressed: 4'b0010, exp_ok: 1'b0, exp_led: 4'b0000};
    vecs[2] = '{stored: 4'b1000, pressed: 4'b1000, exp_ok: 1'b1, exp_led: 4'b1000};
    vecs[3] = '{stored: 4'b0001, pressed: 4'b0011, exp_ok: 1'b0, exp_led: 4'b0000};
    vecs[4] = '{stored: 4'b0011, pressed: 4'b0011, exp_ok: 1'b0, exp_led: 4'b0000};
    vecs[5] = '{stored: 4'b0010, pressed: 4'b0010, exp_ok: 1'b1, exp_led: 4'b0010};
    vecs[6] = '{stored: 4'b0001, pressed: 4'b1111, exp_ok: 1'b0, exp_led: 4'b0000};

    reset = 1'b1; tick = 1'b1; seq_clear = 1'b0; seq_wr = 1'b0;
    seq_colour = 4'b0; arm = 1'b0; button = 4'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_ok", 32'(round_ok), 0);
    check("rst_fail", 32'(round_fail), 0);
    check("rst_led", 32'(led), 0);
    check("rst_score", 32'(score), 0);
    reset = 1'b0;
    step();

    // Three-step round entered correctly.
    clr(); wr(4'b0001); wr(4'b0100); wr(4'b1000);
    arm_pulse();
    check("a_busy_armed", 32'(busy), 1);
    exp_score = 4'd3;
    expect_verdict(1'b1, exp_score);
    press(4'b0001, 4'b0001, "a_led0");
    press(4'b0100, 4'b0100, "a_led1");
    press(4'b1000, 4'b1000, "a_led2");
    check("a_busy_done", 32'(busy), 0);
    check("a_score", 32'(score), 3);

    // Wrong second press: fail, score held.
    clr(); wr(4'b0001); wr(4'b0100); wr(4'b1000);
    arm_pulse();
    expect_verdict(1'b0, exp_score);
    press(4'b0001, 4'b0001, "b_led0");
    press(4'b0010, 4'b0000, "b_led_wrong");
    check("b_busy", 32'(busy), 0);
    check("b_score_held", 32'(score), 3);

    // Single-entry rounds from the vector table.
    for (int i = 0; i < 7; i++) begin
      clr(); wr(vecs[i].stored);
      arm_pulse();
      if (vecs[i].exp_ok) exp_score = 4'd1;
      expect_verdict(vecs[i].exp_ok, exp_score);
      press(vecs[i].pressed, vecs[i].exp_led, "tbl_led");
      check("tbl_busy", 32'(busy), 0);
      check("tbl_score", 32'(score), 32'(exp_score));
    end

    // One-clock glitch is not a press; a later real press still completes.
    clr(); wr(4'b0010);
    arm_pulse();
    button = 4'b0010;
    step();
    button = 4'b0;
    repeat (4) step();
    check("glitch_busy", 32'(busy), 1);
    check("glitch_led", 32'(led), 0);
    exp_score = 4'd1;
    expect_verdict(1'b1, exp_score);
    press(4'b0010, 4'b0010, "glitch_after_led");
    check("glitch_done_busy", 32'(busy), 0);

    // Store writes and clears are ignored while busy: len stays 1.
    clr(); wr(4'b0100);
    arm_pulse();
    wr(4'b0100);
    clr();
    expect_verdict(1'b1, exp_score);
    press(4'b0100, 4'b0100, "busywr_led");
    check("busywr_busy", 32'(busy), 0);

    // Clear beats write in the same cycle, and arm with an empty store is ignored.
    seq_clear = 1'b1; seq_wr = 1'b1; seq_colour = 4'b0001;
    step();
    seq_clear = 1'b0; seq_wr = 1'b0;
    arm_pulse();
    repeat (3) step();
    check("arm_empty_busy", 32'(busy), 0);

    // 17 writes into a 16-entry store: exactly 16 presses finish the round.
    clr();
    for (int i = 0; i < 16; i++) wr(4'(1 << (i % 4)));
    wr(4'b1000);
    arm_pulse();
    exp_score = 4'd15;
    expect_verdict(1'b1, exp_score);
    for (int i = 0; i < 15; i++) begin
      c = 4'(1 << (i % 4));
      press(c, c, "full_led");
    end
    check("full_busy_15", 32'(busy), 1);
    c = 4'(1 << (15 % 4));
    press(c, c, "full_led_last");
    check("full_busy_done", 32'(busy), 0);
    check("full_score", 32'(score), 15);

    // No press after arm.
    clr(); wr(4'b0100);
    arm_pulse();
`ifdef SIMON_CHECK_TIMEOUT_EN
    expect_verdict(1'b0, exp_score);
    repeat (20) step();
    check("timeout_busy", 32'(busy), 0);
`else
    repeat (100) step();
    check("notimeout_busy", 32'(busy), 1);
    exp_score = 4'd1;
    expect_verdict(1'b1, exp_score);
    press(4'b0100, 4'b0100, "notimeout_led");
    check("notimeout_done", 32'(busy), 0);
`endif

    // Reset while holding the first press of a two-step round.
    clr(); wr(4'b0001); wr(4'b0010);
    arm_pulse();
    button = 4'b0001;
    repeat (6) step();
    check("rstmid_led_before", 32'(led), 1);
    reset = 1'b1;
    step();
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_ok", 32'(round_ok), 0);
    check("rstmid_fail", 32'(round_fail), 0);
    check("rstmid_led", 32'(led), 0);
    check("rstmid_score", 32'(score), 0);
    reset = 1'b0;
    button = 4'b0;
    repeat (5) step();
    arm_pulse();
    repeat (3) step();
    check("rstmid_len_cleared", 32'(busy), 0);

    repeat (5) step();
    check("pending_verdicts", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
